counter_ud_param: RTL
=====================

// Module: counter_ud_param
//
// PURPOSE
// - Parametrised up/down counter; next generation of the 4-bit counter_ud.
// - Adds a programmable modulus, step size, wrap or saturate mode, a count enable, a synchronous clear and boundary flags.
// - Used wherever the design needs a loadable modulo-N or saturating event counter; drop-in for counter_ud when WIDTH=4, MAX_VAL=15, STEP=1, MODE=0, en=1, clr=0.
//
// PARAMETERS
// - WIDTH    4     count width in bits (>=2)
// - MAX_VAL  15    terminal value; legal range 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
// - STEP     1     increment/decrement per enabled cycle; must satisfy 1 <= STEP <= MAX_VAL
// - MODE     0     0 = WRAP (modulo MAX_VAL+1), 1 = SATURATE (clamp at 0 / MAX_VAL)
// - RST_VAL  0     count value after reset and clr; must be <= MAX_VAL
//
// PORTS
// - clk       input   1      clock; all state updates on posedge
// - rstn      input   1      asynchronous active-low reset
// - en        input   1      count enable; counts by STEP when high
// - clr       input   1      synchronous clear to RST_VAL
// - load_en   input   1      synchronous load of `load`
// - load      input   WIDTH  load value; clamped to MAX_VAL
// - down      input   1      direction: 1 = decrement, 0 = increment
// - count     output  WIDTH  current count, registered
// - rollover  output  1      1-cycle registered pulse on a boundary event
// - at_zero   output  1      combinational: count == 0
// - at_max    output  1      combinational: count == MAX_VAL
//
// BEHAVIOUR
// - One clock and one reset. Reset is asynchronous and active-low (rstn).
// - While rstn is low: count = RST_VAL and rollover = 0. After release, the first update happens on the next posedge.
// - Priority at each posedge: clr > load_en > en. With none of them high, count holds and rollover = 0.
// - clr: count <= RST_VAL; rollover <= 0.
// - load_en: count <= min(load, MAX_VAL); rollover <= 0. en and down are ignored in that cycle.
// - en, up, WRAP mode:
//   - if count + STEP > MAX_VAL: count <= count + STEP - (MAX_VAL+1) and rollover <= 1;
//   - else count <= count + STEP.
// - en, down, WRAP mode:
//   - if count < STEP: count <= count + (MAX_VAL+1) - STEP and rollover <= 1;
//   - else count <= count - STEP.
// - en, SATURATE mode:
//   - count moves by STEP and clamps at MAX_VAL (up) or 0 (down).
//   - rollover <= 1 whenever the unclamped result would leave 0..MAX_VAL. This includes a step attempted while already at the bound.
//   - count stays at the bound.
// - Arithmetic is done at WIDTH+1 bits internally, so count + STEP never overflows silently. count never leaves 0..MAX_VAL.
// - rollover is high in the cycle where the new count is visible and low in the next cycle unless another boundary event occurs. Back-to-back events give a continuous high.
// - Latency: count and rollover change one clock after the sampled inputs. at_zero and at_max follow count with no added delay.
// - Reset asserted mid-count: count and rollover go to their reset values immediately, without waiting for clk. A pending rollover pulse is dropped.
// - Parameter violations are caught by elaboration-time assertions ($error). No runtime checking.
//
// TESTING
// - Config: WIDTH=4, MAX_VAL=9, STEP=1, MODE=0 unless stated otherwise.
// - Up-wrap: load 8, en=1, down=0 -> 8,9,0,1; rollover high only when count=0; at_max=1 when count=9.
// - Down-wrap: load 1, en=1, down=1 -> 1,0,9,8; rollover high only when count=9; at_zero=1 when count=0.
// - Load clamp and priority:
//   - load=12, load_en=1, en=1 -> count=9, rollover=0.
//   - Same cycle with clr=1 -> count=0.
// - STEP=3, wrap: from 8 counting up -> 8,1,4,7,0; rollover on the 1 and on the 0.
// - MODE=1: from 8 counting up for 4 clocks -> 8,9,9,9; rollover high on the two 9-hold cycles only, not on the 8->9 step.
// - Async reset: drop rstn mid-period with count=5 and rollover=1 -> count=0 and rollover=0 before the next posedge. Counting resumes 0,1,... after release.

Source files
------------

// File: rtl/counter_ud_param_if.sv
// rtl/counter_ud_param_if.sv - control/status bundle for counter_ud_param
// master drives the controls and observes the count; slave is the counter.
interface counter_ud_param_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             clr;
   logic             load_en;
   logic [WIDTH-1:0] load;
   logic             down;
   logic [WIDTH-1:0] count;
   logic             rollover;
   logic             at_zero;
   logic             at_max;

   modport master (
      output en, clr, load_en, load, down,
      input  count, rollover, at_zero, at_max
   );

   modport slave (
      input  en, clr, load_en, load, down,
      output count, rollover, at_zero, at_max
   );
endinterface

// File: rtl/counter_ud_param.sv
// rtl/counter_ud_param.sv - parametrised up/down counter with modulus, step, wrap/saturate
// Priority clr > load_en > en; rollover is a registered pulse on boundary events.
module counter_ud_param #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 15,
   parameter int STEP    = 1,
   parameter int MODE    = 0,
   parameter int RST_VAL = 0
) (
   input  logic clk,
   input  logic rstn,
   counter_ud_param_if.slave bus
);

   if (WIDTH < 2) begin : g_bad_width
      $error("counter_ud_param: WIDTH must be >= 2");
   end
   if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
      $error("counter_ud_param: MAX_VAL must be in 1..2**WIDTH-1");
   end
   if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
      $error("counter_ud_param: STEP must be in 1..MAX_VAL");
   end
   if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("counter_ud_param: MODE must be 0 (wrap) or 1 (saturate)");
   end
   if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_rst
      $error("counter_ud_param: RST_VAL must be in 0..MAX_VAL");
   end

   // Boundary tests need the carry bit; the wrapped results are exact modulo 2**WIDTH.
   localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] MOD_W    = WIDTH'(MAX_VAL + 1);
   localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             roll_q, roll_d;
   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   load_ext;
   logic             up_over;
   logic             dn_under;

   always_comb begin
      cnt_ext  = {1'b0, count_q};
      up_sum   = cnt_ext + STEP_EXT;
      load_ext = {1'b0, bus.load};
      up_over  = (up_sum > MAX_EXT);
      dn_under = (cnt_ext < STEP_EXT);
   end

   always_comb begin
      count_d = count_q;
      roll_d  = 1'b0;
      if (bus.clr) begin
         count_d = RST_W;
      end else if (bus.load_en) begin
         count_d = (load_ext > MAX_EXT) ? MAX_W : bus.load;
      end else if (bus.en) begin
         if (!bus.down) begin
            if (up_over) begin
               roll_d  = 1'b1;
               count_d = (MODE == 1) ? MAX_W : (count_q + STEP_W - MOD_W);
            end else begin
               count_d = count_q + STEP_W;
            end
         end else begin
            if (dn_under) begin
               roll_d  = 1'b1;
               count_d = (MODE == 1) ? '0 : (count_q + MOD_W - STEP_W);
            end else begin
               count_d = count_q - STEP_W;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= RST_W;
         roll_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         roll_q  <= roll_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.rollover = roll_q;
   assign bus.at_zero  = (count_q == '0);
   assign bus.at_max   = (count_q == MAX_W);

endmodule
